// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master round-robin memory bus arbiter with bus watchdog
module mem_bus_arbiter #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   // master 0 (CPU)
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_data_out,
   input  logic [3:0]  m0_data_mask,
   input  logic        m0_rd_req,
   input  logic        m0_wr_req,
   output logic [31:0] m0_data_in,
   output logic        m0_done,
   output logic        m0_timeout,
   // master 1 (DMA / video fetch)
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_data_out,
   input  logic [3:0]  m1_data_mask,
   input  logic        m1_rd_req,
   input  logic        m1_wr_req,
   output logic [31:0] m1_data_in,
   output logic        m1_done,
   output logic        m1_timeout,
   // slave side
   output logic [31:0] s_addr,
   output logic [31:0] s_data_out,
   output logic [3:0]  s_data_mask,
   output logic        s_rd_req,
   output logic        s_wr_req,
   input  logic [31:0] s_data_in,
   input  logic        s_done,
   // status
   output logic        busy,
   output logic        owner
);

   // Counter is sized so TIMEOUT_CYCLES-1 is its largest reachable value;
   // GRANT always exits there, so it never wraps.
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic            owner_q, owner_d;
   logic            last_owner_q, last_owner_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic            in_grant;
   logic            m0_any, m1_any;
   logic            own_rd, own_wr;
   logic            xfer_done, xfer_timeout, xfer_withdraw;

   // Request decode and end-of-transfer conditions for the current owner
   always_comb begin
      in_grant      = (state_q == ST_GRANT);
      m0_any        = m0_rd_req | m0_wr_req;
      m1_any        = m1_rd_req | m1_wr_req;
      own_rd        = owner_q ? m1_rd_req : m0_rd_req;
      own_wr        = owner_q ? m1_wr_req : m0_wr_req;
      // s_done wins over a coincident deadline
      xfer_done     = in_grant & s_done;
      xfer_timeout  = in_grant & ~s_done & (cnt_q == CNT_LAST);
      xfer_withdraw = in_grant & ~s_done & ~(own_rd | own_wr);
   end

   // Slave-side mux: owner's signals while granted, master 0 otherwise with requests forced low
   always_comb begin
      s_addr      = m0_addr;
      s_data_out  = m0_data_out;
      s_data_mask = m0_data_mask;
      s_rd_req    = 1'b0;
      s_wr_req    = 1'b0;
      if (in_grant) begin
         if (owner_q) begin
            s_addr      = m1_addr;
            s_data_out  = m1_data_out;
            s_data_mask = m1_data_mask;
         end
         s_rd_req = own_rd;
         s_wr_req = own_wr;
      end
   end

   // Master-side strobes go only to the owner; read data is broadcast
   always_comb begin
      m0_data_in = s_data_in;
      m1_data_in = s_data_in;
      m0_done    = xfer_done    & ~owner_q;
      m1_done    = xfer_done    &  owner_q;
      m0_timeout = xfer_timeout & ~owner_q;
      m1_timeout = xfer_timeout &  owner_q;
      busy       = in_grant;
      owner      = owner_q;
   end

   // Arbitration and watchdog next-state logic
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      cnt_d        = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (m0_any || m1_any) begin
               state_d = ST_GRANT;
               cnt_d   = '0;
               if (m0_any && m1_any) begin
                  owner_d = ~last_owner_q;
               end else begin
                  owner_d = m1_any;
               end
            end
         end
         ST_GRANT: begin
            if (xfer_done || xfer_timeout || xfer_withdraw) begin
               // Every exit passes through IDLE, giving the turnaround cycle
               state_d      = ST_IDLE;
               last_owner_d = owner_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset abandons any transfer without a strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         cnt_q        <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

   logic        clk;
   logic        rst;
   logic [31:0] m0_addr, m1_addr, m0_data_out, m1_data_out;
   logic [3:0]  m0_data_mask, m1_data_mask;
   logic        m0_rd_req, m0_wr_req, m1_rd_req, m1_wr_req;
   logic [31:0] m0_data_in, m1_data_in;
   logic        m0_done, m1_done, m0_timeout, m1_timeout;
   logic [31:0] s_addr, s_data_out, s_data_in;
   logic [3:0]  s_data_mask;
   logic        s_rd_req, s_wr_req, s_done;
   logic        busy, owner;

   int vecs = 0;
   int errs = 0;

   mem_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst),
      .m0_addr(m0_addr), .m0_data_out(m0_data_out), .m0_data_mask(m0_data_mask),
      .m0_rd_req(m0_rd_req), .m0_wr_req(m0_wr_req), .m0_data_in(m0_data_in),
      .m0_done(m0_done), .m0_timeout(m0_timeout),
      .m1_addr(m1_addr), .m1_data_out(m1_data_out), .m1_data_mask(m1_data_mask),
      .m1_rd_req(m1_rd_req), .m1_wr_req(m1_wr_req), .m1_data_in(m1_data_in),
      .m1_done(m1_done), .m1_timeout(m1_timeout),
      .s_addr(s_addr), .s_data_out(s_data_out), .s_data_mask(s_data_mask),
      .s_rd_req(s_rd_req), .s_wr_req(s_wr_req), .s_data_in(s_data_in),
      .s_done(s_done), .busy(busy), .owner(owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // strobe bundle: {m0_done, m1_done, m0_timeout, m1_timeout}
   function automatic logic [3:0] strobes();
      return {m0_done, m1_done, m0_timeout, m1_timeout};
   endfunction

   task automatic to_pos();
      @(posedge clk);
      #1;
   endtask

   task automatic to_neg();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      m0_addr = 32'h1000_0000; m1_addr = 32'h2000_0000;
      m0_data_out = 32'h0000_00AA; m1_data_out = 32'h0000_00BB;
      m0_data_mask = 4'hF; m1_data_mask = 4'hF;
      m0_rd_req = 0; m0_wr_req = 0; m1_rd_req = 0; m1_wr_req = 0;
      s_data_in = 32'h0; s_done = 0;
      to_pos(); to_pos();
      rst = 1'b0;
      to_neg();
      vecs++;
      if ({busy, owner, s_rd_req, s_wr_req, strobes()} !== 8'b0) begin
         errs++;
         $display("FAIL reset_state got %b want %b", {busy, owner, s_rd_req, s_wr_req, strobes()}, 8'b0);
      end
   endtask

   task automatic test_single_read();
      to_pos();
      m0_rd_req = 1; m0_addr = 32'h4000_0000;
      to_neg();
      vecs++;
      if ({busy, s_rd_req} !== 2'b00) begin
         errs++; $display("FAIL rd_latency_idle got %b want 00", {busy, s_rd_req});
      end
      for (int g = 1; g <= 4; g++) begin
         to_pos();
         if (g == 4) begin s_done = 1; s_data_in = 32'hDEAD_BEEF; end
         to_neg();
         vecs++;
         if ({busy, owner, s_rd_req, s_addr} !== {3'b101, 32'h4000_0000}) begin
            errs++; $display("FAIL rd_grant g=%0d got %h want %h", g, {busy, owner, s_rd_req, s_addr}, {3'b101, 32'h4000_0000});
         end
         vecs++;
         if (strobes() !== ((g == 4) ? 4'b1000 : 4'b0000)) begin
            errs++; $display("FAIL rd_strobe g=%0d got %b want %b", g, strobes(), (g == 4) ? 4'b1000 : 4'b0000);
         end
      end
      vecs++;
      if (m0_data_in !== 32'hDEAD_BEEF) begin
         errs++; $display("FAIL rd_data got %h want deadbeef", m0_data_in);
      end
      to_pos();
      s_done = 0; m0_rd_req = 0;
      to_neg();
      vecs++;
      if ({busy, strobes()} !== 5'b0) begin
         errs++; $display("FAIL rd_after got %b want 00000", {busy, strobes()});
      end
   endtask

   task automatic test_round_robin();
      logic       eb, eo;
      logic [3:0] es;
      rst = 1; to_pos(); rst = 0;
      m0_rd_req = 1; m1_rd_req = 1; s_done = 1;
      for (int i = 0; i <= 8; i++) begin
         to_neg();
         eb = (i % 2 == 1);
         eo = (i == 0) ? 1'b0 : (((i - 1) / 2) % 2 == 1);
         es = !eb ? 4'b0000 : (eo ? 4'b0100 : 4'b1000);
         vecs++;
         if ({busy, owner, s_rd_req, strobes()} !== {eb, eo, eb, es}) begin
            errs++; $display("FAIL rr i=%0d got %b want %b", i, {busy, owner, s_rd_req, strobes()}, {eb, eo, eb, es});
         end
         if (i == 8) begin m0_rd_req = 0; m1_rd_req = 0; s_done = 0; end
         to_pos();
      end
   endtask

   task automatic test_timeout();
      m1_wr_req = 1; m1_data_mask = 4'b0011; m1_addr = 32'h2000_0040; m0_addr = 32'h1234_5678;
      for (int g = 1; g <= 8; g++) begin
         to_pos();
         to_neg();
         vecs++;
         if ({busy, owner, s_wr_req, s_data_mask, s_addr} !== {3'b111, 4'b0011, 32'h2000_0040}) begin
            errs++; $display("FAIL to_grant g=%0d got %h want %h", g, {busy, owner, s_wr_req, s_data_mask, s_addr}, {3'b111, 4'b0011, 32'h2000_0040});
         end
         vecs++;
         if (strobes() !== ((g == 8) ? 4'b0001 : 4'b0000)) begin
            errs++; $display("FAIL to_strobe g=%0d got %b want %b", g, strobes(), (g == 8) ? 4'b0001 : 4'b0000);
         end
      end
      m1_wr_req = 0;
      to_pos();
      to_neg();
      vecs++;
      if ({busy, s_wr_req, strobes(), s_addr, s_data_mask} !== {6'b0, 32'h1234_5678, 4'hF}) begin
         errs++; $display("FAIL to_after got %h want %h", {busy, s_wr_req, strobes(), s_addr, s_data_mask}, {6'b0, 32'h1234_5678, 4'hF});
      end
   endtask

   task automatic test_done_at_deadline();
      m0_rd_req = 1;
      for (int g = 1; g <= 8; g++) begin
         to_pos();
         if (g == 8) s_done = 1;
         to_neg();
         vecs++;
         if ({busy, owner, strobes()} !== {2'b10, (g == 8) ? 4'b1000 : 4'b0000}) begin
            errs++; $display("FAIL deadline g=%0d got %b want %b", g, {busy, owner, strobes()}, {2'b10, (g == 8) ? 4'b1000 : 4'b0000});
         end
      end
      m0_rd_req = 0; s_done = 0;
      to_pos();
      to_neg();
      vecs++;
      if ({busy, strobes()} !== 5'b0) begin
         errs++; $display("FAIL deadline_after got %b want 00000", {busy, strobes()});
      end
   endtask

   task automatic test_withdraw_stray();
      m1_rd_req = 1;
      to_pos();
      to_neg();
      vecs++;
      if ({busy, owner, s_rd_req} !== 3'b111) begin
         errs++; $display("FAIL wd_grant got %b want 111", {busy, owner, s_rd_req});
      end
      to_pos();
      m1_rd_req = 0;
      to_neg();
      vecs++;
      if ({busy, s_rd_req, strobes()} !== 6'b100000) begin
         errs++; $display("FAIL wd_drop got %b want 100000", {busy, s_rd_req, strobes()});
      end
      to_pos();
      to_neg();
      vecs++;
      if ({busy, strobes()} !== 5'b0) begin
         errs++; $display("FAIL wd_idle got %b want 00000", {busy, strobes()});
      end
      to_pos();
      s_done = 1;
      to_neg();
      vecs++;
      if ({busy, s_rd_req, s_wr_req, strobes()} !== 7'b0) begin
         errs++; $display("FAIL stray_done got %b want 0000000", {busy, s_rd_req, s_wr_req, strobes()});
      end
      to_pos();
      s_done = 0;
      to_neg();
      vecs++;
      if (busy !== 1'b0) begin
         errs++; $display("FAIL stray_after got %b want 0", busy);
      end
   endtask

   task automatic test_reset_mid();
      m0_wr_req = 1;
      to_pos();
      to_neg();
      vecs++;
      if ({busy, owner, s_wr_req} !== 3'b101) begin
         errs++; $display("FAIL rm_grant got %b want 101", {busy, owner, s_wr_req});
      end
      to_pos();
      rst = 1;
      to_pos();
      rst = 0; m0_wr_req = 0;
      to_neg();
      vecs++;
      if ({busy, owner, s_rd_req, s_wr_req, strobes()} !== 8'b0) begin
         errs++; $display("FAIL rm_after got %b want 00000000", {busy, owner, s_rd_req, s_wr_req, strobes()});
      end
      m0_rd_req = 1; m1_rd_req = 1;
      to_pos();
      s_done = 1;
      to_neg();
      vecs++;
      if ({busy, owner, strobes()} !== 6'b101000) begin
         errs++; $display("FAIL rm_tie got %b want 101000", {busy, owner, strobes()});
      end
      m0_rd_req = 0; m1_rd_req = 0; s_done = 0;
      to_pos();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_timeout();
      test_done_at_deadline();
      test_withdraw_stray();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter that shares the single memory-access bus between the CPU and a second bus master, such as a DMA or video fetch unit. It uses round-robin arbitration and holds each grant until the transfer completes. It also owns the bus watchdog: when the slave side does not answer within a fixed number of cycles, it generates the timeout that the CPU converts into an access-fault exception. It sits between the masters' memory-access ports and the memory/peripheral interconnect.

## Interface
- TIMEOUT_CYCLES, 1024: cycles a granted transfer may wait for s_done before it is aborted; minimum 2.
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- m0_addr, m1_addr  in  32  master byte addresses (master 0 = CPU)
- m0_data_out, m1_data_out  in  32  master write data
- m0_data_mask, m1_data_mask  in  4  master byte-lane masks
- m0_rd_req, m0_wr_req, m1_rd_req, m1_wr_req  in  1  level requests; at most one of rd/wr is high per master
- m0_data_in, m1_data_in  out  32  read data; both are driven from s_data_in
- m0_done, m1_done  out  1  one-cycle completion strobe to the owning master
- m0_timeout, m1_timeout  out  1  one-cycle abort strobe to the owning master
- s_addr, s_data_out  out  32  slave address and write data, muxed from the owner
- s_data_mask  out  4  slave byte-lane mask, muxed from the owner
- s_rd_req, s_wr_req  out  1  slave requests
- s_data_in  in  32  slave read data
- s_done  in  1  slave completion
- busy  out  1  high while a grant is held
- owner  out  1  current or last granted master

## Operation
- There are two states: IDLE and GRANT. Registers: owner, last_owner, and a timeout counter of width $clog2(TIMEOUT_CYCLES).
- IDLE:
  - s_rd_req, s_wr_req, all done strobes and all timeout strobes are 0.
  - At a clock edge where any mX_rd_req or mX_wr_req is high, the block enters GRANT.
  - If only one master requests, that master becomes owner.
  - If both request, owner becomes !last_owner.
  - The counter clears to 0 on entry to GRANT.
- GRANT:
  - s_addr, s_data_out, s_data_mask, s_rd_req and s_wr_req come combinationally from the owner's inputs.
  - The non-owner receives no strobes; its request stays pending.
- Completion: when s_done is high, m[owner]_done=1 in the same cycle. At that edge the block returns to IDLE and last_owner takes the value of owner.
- Watchdog: the counter increments on each GRANT cycle without s_done. When counter==TIMEOUT_CYCLES-1 and s_done is 0:
  - m[owner]_timeout=1 in that cycle.
  - The block returns to IDLE at the edge and last_owner takes the value of owner.
  - s_done arriving in that same cycle has priority, and no timeout is issued.
- Withdrawal: if the owner drops both its requests while in GRANT and s_done is 0, the block returns to IDLE at the edge with no strobe. last_owner takes the value of owner.
- Stray s_done in IDLE is ignored, and no master strobe is produced.
- s_data_in is routed to both masters unconditionally. A master qualifies it with its own done.
- The mux default when not in GRANT is master 0's address, data and mask. Requests are forced to 0 in this case.
- Reset: state IDLE, owner=0, last_owner=1 (master 0 wins the first tie), counter 0, busy=0. All strobes and slave requests are 0 from the first cycle after the reset edge. A transfer in flight is abandoned with no strobe issued.

## Timing
- Arbitration latency: a request sampled at edge N appears on s_*_req in cycle N+1. This is one cycle of latency from IDLE.
- done and timeout are combinational in the cycle they occur and last exactly one cycle.
- There is one mandatory IDLE turnaround cycle after every completion, timeout or withdrawal. This means a master that drops its request on the edge after done is never re-granted stale.
- Back-to-back contention alternates strictly: grant m0, IDLE, grant m1, IDLE, grant m0, and so on.
- Worst-case wait for a requester is one foreign transfer of at most TIMEOUT_CYCLES cycles plus 2 cycles.
- The counter never wraps, because GRANT exits at TIMEOUT_CYCLES-1.

## Test plan
- Single read:
  - Stimulus: after reset, m0_rd_req=1 with addr 0x40000000; the slave asserts s_done with data 0xDEADBEEF three cycles after s_rd_req.
  - Required: s_rd_req rises one cycle after the request; m0_done=1 together with m0_data_in=0xDEADBEEF; busy=0 on the following cycle.
- Tie and round-robin:
  - Stimulus: both masters hold their requests continuously; the slave answers in 1 cycle.
  - Required: grants run m0, m1, m0, m1; each grant is separated by exactly one IDLE cycle; the non-owner never sees a strobe.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8; m1_wr_req with mask 4'b0011; the slave never responds.
  - Required: m1_timeout=1 for one cycle, 8 cycles after the grant; s_wr_req=0 on the next cycle.
- Done at the deadline:
  - Stimulus: s_done arrives exactly in the cycle where counter==TIMEOUT_CYCLES-1.
  - Required: m_done=1 and timeout=0.
- Withdrawal and stray done:
  - Stimulus: the owner drops its request mid-grant; then s_done is pulsed while the block is in IDLE.
  - Required: return to IDLE with no strobes, and no master strobe from the stray done.
- Reset mid-transfer:
  - Stimulus: assert rst during GRANT.
  - Required: all outputs are 0 the next cycle and owner=0; a later tie grants m0 first.
